sw_debounce2: RTL and testbench

Two-channel switch conditioner that sits directly upstream of the two-input gate stage: it takes the raw board switches, synchronises them to the system clock, filters contact bounce, and drives clean levels into that stage's SW0/SW1 inputs. It also produces one-cycle rise/fall pulses per switch for stages that need edge events rather than levels. Both channels are identical and fully independent.

---
 rtl/sw_debounce2.sv | 87 ++++++++
 tb/tb_sw_debounce2.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce2.sv
// Two-channel switch conditioner: synchronise, debounce, and
// emit one-cycle rise/fall pulses per channel.
module sw_debounce2 #(
  parameter int STABLE_CNT = 50000,
  parameter int CNT_W      = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] SW_IN,
  output logic [1:0] SW_OUT,
  output logic [1:0] SW_RISE,
  output logic [1:0] SW_FALL
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(STABLE_CNT - 1);

  for (genvar g = 0; g < 2; g++) begin : g_ch
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_e           state;

    // Channel state: sync chain, level, counter, pulses.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        out_q  <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        s1_q   <= s1_d;
        s2_q   <= s2_d;
        out_q  <= out_d;
        rise_q <= rise_d;
        fall_q <= fall_d;
        cnt_q  <= cnt_d;
      end
    end

    // Mode follows agreement of synced input with output;
    // a full run of disagreement commits the new level.
    always_comb begin
      s1_d   = SW_IN[g];
      s2_d   = s1_q;
      out_d  = out_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      cnt_d  = cnt_q;
      state  = (s2_q == out_q) ? ST_STABLE
                               : ST_PENDING;
      unique case (state)
        ST_STABLE: begin
          cnt_d = '0;
        end
        ST_PENDING: begin
          if (cnt_q == LAST) begin
            out_d  = s2_q;
            rise_d = s2_q;
            fall_d = ~s2_q;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          cnt_d = '0;
        end
      endcase
    end

    assign SW_OUT[g]  = out_q;
    assign SW_RISE[g] = rise_q;
    assign SW_FALL[g] = fall_q;
  end

endmodule

// File: tb/tb_sw_debounce2.sv
// Bench for sw_debounce2: directed scenarios plus random
// stimulus against a history-window reference model.
module tb_sw_debounce2;

  localparam int ST = 4;

  logic       CLK;
  logic       RST_N;
  logic [1:0] SW_IN;
  logic [1:0] SW_OUT;
  logic [1:0] SW_RISE;
  logic [1:0] SW_FALL;

  int passed = 0;
  int total  = 0;

  sw_debounce2 #(
    .STABLE_CNT(ST),
    .CNT_W     (3)
  ) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .SW_IN  (SW_IN),
    .SW_OUT (SW_OUT),
    .SW_RISE(SW_RISE),
    .SW_FALL(SW_FALL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: a level is accepted once the last ST
  // synchronised samples all differ from the current output.
  logic [1:0]    s1m, s2m, outm, risem, fallm;
  logic [ST-1:0] hist [2];
  int            fill [2];

  task automatic reset_model();
    s1m = 0; s2m = 0; outm = 0;
    risem = 0; fallm = 0;
    for (int c = 0; c < 2; c++) begin
      hist[c] = '0;
      fill[c] = 0;
    end
  endtask

  task automatic model_edge(input logic [1:0] sw);
    risem = 0;
    fallm = 0;
    for (int c = 0; c < 2; c++) begin
      hist[c] = {hist[c][ST-2:0], s2m[c]};
      if (fill[c] < ST) fill[c]++;
      if (fill[c] == ST &&
          hist[c] == {ST{~outm[c]}}) begin
        outm[c]  = ~outm[c];
        risem[c] = outm[c];
        fallm[c] = ~outm[c];
      end
    end
    s2m = s1m;
    s1m = sw;
  endtask

  task automatic step(input logic [1:0] sw);
    SW_IN = sw;
    @(posedge CLK);
    model_edge(sw);
    #1;
  endtask

  task automatic test_reset();
    SW_IN = 2'b11;
    RST_N = 1'b0;
    reset_model();
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
      total++;
      if ({SW_OUT, SW_RISE, SW_FALL} !== 6'b0)
        $display("FAIL reset_hold: got %b want 000000",
                 {SW_OUT, SW_RISE, SW_FALL});
      else passed++;
    end
    RST_N = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(2'b11);
      total++;
      if (k < 6 && {SW_OUT, SW_RISE} !== 4'b0000)
        $display("FAIL reset_early k=%0d: got %b want 0000",
                 k, {SW_OUT, SW_RISE});
      else if (k == 6 && {SW_OUT, SW_RISE} !== 4'b1111)
        $display("FAIL reset_rise: got %b want 1111",
                 {SW_OUT, SW_RISE});
      else if (k == 7 && {SW_OUT, SW_RISE} !== 4'b1100)
        $display("FAIL reset_pulse_end: got %b want 1100",
                 {SW_OUT, SW_RISE});
      else passed++;
    end
  endtask

  task automatic test_fall_both();
    for (int k = 1; k <= 7; k++) begin
      step(2'b00);
      total++;
      if ({SW_OUT, SW_RISE, SW_FALL} !==
          {outm, risem, fallm})
        $display("FAIL fall_model k=%0d: got %b want %b", k,
                 {SW_OUT, SW_RISE, SW_FALL},
                 {outm, risem, fallm});
      else passed++;
      if (k == 6) begin
        total++;
        if ({SW_OUT, SW_RISE, SW_FALL} !== 6'b000011)
          $display("FAIL fall_both: got %b want 000011",
                   {SW_OUT, SW_RISE, SW_FALL});
        else passed++;
      end
    end
  endtask

  task automatic test_glitch();
    for (int k = 1; k <= 11; k++) begin
      step(k <= 3 ? 2'b01 : 2'b00);
      total++;
      if (SW_OUT[0] !== 1'b0 || SW_RISE[0] !== 1'b0)
        $display("FAIL glitch k=%0d: got out=%b rise=%b want 0 0",
                 k, SW_OUT[0], SW_RISE[0]);
      else passed++;
    end
  endtask

  task automatic test_clean_step();
    for (int k = 1; k <= 7; k++) begin
      step(2'b01);
      total++;
      if (k < 6 && {SW_OUT, SW_RISE, SW_FALL} !== 6'b0)
        $display("FAIL step_early k=%0d: got %b want 000000",
                 k, {SW_OUT, SW_RISE, SW_FALL});
      else if (k == 6 &&
               {SW_OUT, SW_RISE, SW_FALL} !== 6'b010100)
        $display("FAIL step_rise: got %b want 010100",
                 {SW_OUT, SW_RISE, SW_FALL});
      else if (k == 7 &&
               {SW_OUT, SW_RISE, SW_FALL} !== 6'b010000)
        $display("FAIL step_after: got %b want 010000",
                 {SW_OUT, SW_RISE, SW_FALL});
      else passed++;
    end
  endtask

  task automatic test_bounce();
    logic b;
    for (int k = 1; k <= 11; k++) begin
      b = (k >= 5) ? 1'b1 : k[0];
      step({b, 1'b1});
      total++;
      if (k < 10 && (SW_OUT[1] !== 1'b0 || SW_RISE[1] !== 1'b0))
        $display("FAIL bounce_early k=%0d: got out=%b rise=%b want 0 0",
                 k, SW_OUT[1], SW_RISE[1]);
      else if (k == 10 &&
               (SW_OUT[1] !== 1'b1 || SW_RISE[1] !== 1'b1))
        $display("FAIL bounce_rise: got out=%b rise=%b want 1 1",
                 SW_OUT[1], SW_RISE[1]);
      else if (k == 11 &&
               (SW_OUT[1] !== 1'b1 || SW_RISE[1] !== 1'b0))
        $display("FAIL bounce_after: got out=%b rise=%b want 1 0",
                 SW_OUT[1], SW_RISE[1]);
      else passed++;
    end
  endtask

  task automatic test_mid_reset();
    #2 RST_N = 1'b0;
    #1;
    reset_model();
    total++;
    if ({SW_OUT, SW_RISE, SW_FALL} !== 6'b0)
      $display("FAIL async_reset: got %b want 000000",
               {SW_OUT, SW_RISE, SW_FALL});
    else passed++;
    SW_IN = 2'b00;
    @(posedge CLK);
    #1 RST_N = 1'b1;
    for (int k = 1; k <= 4; k++) step(2'b11);
    #2 RST_N = 1'b0;
    #1;
    reset_model();
    total++;
    if ({SW_OUT, SW_RISE, SW_FALL} !== 6'b0)
      $display("FAIL mid_reset: got %b want 000000",
               {SW_OUT, SW_RISE, SW_FALL});
    else passed++;
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step(2'b11);
      total++;
      if ({SW_OUT, SW_RISE, SW_FALL} !==
          {outm, risem, fallm})
        $display("FAIL mid_reset_model k=%0d: got %b want %b",
                 k, {SW_OUT, SW_RISE, SW_FALL},
                 {outm, risem, fallm});
      else passed++;
      if (k == 6) begin
        total++;
        if ({SW_OUT, SW_RISE} !== 4'b1111)
          $display("FAIL mid_reset_rise: got %b want 1111",
                   {SW_OUT, SW_RISE});
        else passed++;
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] cur;
    int         hold;
    cur  = 2'b11;
    hold = 0;
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        cur  = 2'($urandom);
        hold = $urandom_range(1, 8);
      end
      hold--;
      step(cur);
      total++;
      if ({SW_OUT, SW_RISE, SW_FALL} !==
          {outm, risem, fallm})
        $display("FAIL random i=%0d: got %b want %b", i,
                 {SW_OUT, SW_RISE, SW_FALL},
                 {outm, risem, fallm});
      else passed++;
      total++;
      if ((SW_RISE & SW_FALL) !== 2'b00)
        $display("FAIL rise_fall_excl i=%0d: got %b want 00",
                 i, SW_RISE & SW_FALL);
      else passed++;
    end
  endtask

  initial begin
    RST_N = 1'b0;
    SW_IN = 2'b00;
    test_reset();
    test_fall_both();
    test_glitch();
    test_clean_step();
    test_bounce();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
